// File: rtl/ir_fetch.sv
// Instruction fetch/decode sequencer: fetches a word for pc_addr, resolves HALT/JMP/JZ locally,
// and hands every other instruction to the execute stage over a valid/ready handshake.
module ir_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  pc_addr,
    output logic        mem_req,
    input  logic        mem_valid,
    input  logic [15:0] mem_data,
    input  logic        flag_z,
    output logic        inc_pc,
    output logic        branch,
    output logic [15:0] bus,
    output logic [15:0] ir,
    output logic [5:0]  ir_addr,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] icount,
    output logic        halted,
    output logic        err
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(14);
    localparam logic [OP_W-1:0]  OP_HALT   = 4'hF;
    localparam logic [OP_W-1:0]  OP_JMP    = 4'hE;
    localparam logic [OP_W-1:0]  OP_JZ     = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   w_ir_nxt;
    logic [ADDR_W-1:0]   r_ir_addr;
    logic [ADDR_W-1:0]   w_ir_addr_nxt;
    logic [DATA_W-1:0]   r_icount;
    logic [DATA_W-1:0]   w_icount_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]    w_wait_cnt_nxt;
    logic [OP_W-1:0]     w_opcode;

    assign w_opcode = r_ir[DATA_W-1 -: OP_W];
    assign ir       = r_ir;
    assign ir_addr  = r_ir_addr;
    assign icount   = r_icount;
    assign err      = r_err;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ir       <= '0;
            r_ir_addr  <= '0;
            r_icount   <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_addr  <= w_ir_addr_nxt;
            r_icount   <= w_icount_nxt;
            r_err      <= w_err_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_ir_nxt       = r_ir;
        w_ir_addr_nxt  = r_ir_addr;
        w_icount_nxt   = r_icount;
        w_err_nxt      = r_err;
        w_wait_cnt_nxt = r_wait_cnt;
        mem_req        = 1'b0;
        inc_pc         = 1'b0;
        branch         = 1'b0;
        bus            = '0;
        ir_valid       = 1'b0;
        halted         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req        = 1'b1;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                mem_req        = 1'b1;
                w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                // A response in the last allowed cycle still beats the timeout
                if (mem_valid) begin
                    w_ir_nxt      = mem_data;
                    w_ir_addr_nxt = pc_addr;
                    w_state_nxt   = S_DECODE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_HALT: begin
                        w_icount_nxt = r_icount + DATA_W'(1);
                        w_state_nxt  = S_HALT;
                    end
                    OP_JMP: begin
                        branch       = 1'b1;
                        bus          = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
                        w_icount_nxt = r_icount + DATA_W'(1);
                        w_state_nxt  = S_FETCH;
                    end
                    OP_JZ: begin
                        if (flag_z) begin
                            branch = 1'b1;
                            bus    = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
                        end else begin
                            inc_pc = 1'b1;
                        end
                        w_icount_nxt = r_icount + DATA_W'(1);
                        w_state_nxt  = S_FETCH;
                    end
                    default: begin
                        w_state_nxt = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                ir_valid = 1'b1;
                if (ir_ready) begin
                    inc_pc       = 1'b1;
                    w_icount_nxt = r_icount + DATA_W'(1);
                    w_state_nxt  = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ir_fetch.sv
// Bench for ir_fetch: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ir_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  pc_addr = '0;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic        flag_z = 1'b0;
    logic        ir_ready = 1'b0;
    logic        mem_req, inc_pc, branch, ir_valid, halted, err;
    logic [15:0] bus, ir, icount;
    logic [5:0]  ir_addr;

    ir_fetch dut (
        .clk(clk), .rst(rst), .start(start), .pc_addr(pc_addr),
        .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mem_data),
        .flag_z(flag_z), .inc_pc(inc_pc), .branch(branch), .bus(bus),
        .ir(ir), .ir_addr(ir_addr), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .icount(icount), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase of the fetch loop plus the architectural results
    localparam int P_IDLE = 0, P_FETCH = 1, P_WAIT = 2, P_DECODE = 3, P_ISSUE = 4, P_HALT = 5;
    int          m_phase  = P_IDLE;
    int          m_waited = 0;
    logic [15:0] m_ir     = '0;
    logic [5:0]  m_addr   = '0;
    logic [15:0] m_cnt    = '0;
    logic        m_err    = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase <= P_IDLE; m_waited <= 0; m_ir <= '0; m_addr <= '0; m_cnt <= '0; m_err <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE:  if (start) m_phase <= P_FETCH;
                P_FETCH: begin m_waited <= 0; m_phase <= P_WAIT; end
                P_WAIT: begin
                    m_waited <= m_waited + 1;
                    if (mem_valid) begin
                        m_ir <= mem_data; m_addr <= pc_addr; m_phase <= P_DECODE;
                    end else if (m_waited + 1 >= 15) begin
                        m_err <= 1'b1; m_phase <= P_HALT;
                    end
                end
                P_DECODE: begin
                    if (m_ir[15:12] == 4'hF) begin
                        m_cnt <= m_cnt + 16'd1; m_phase <= P_HALT;
                    end else if (m_ir[15:12] == 4'hE || m_ir[15:12] == 4'hD) begin
                        m_cnt <= m_cnt + 16'd1; m_phase <= P_FETCH;
                    end else begin
                        m_phase <= P_ISSUE;
                    end
                end
                P_ISSUE: if (ir_ready) begin m_cnt <= m_cnt + 16'd1; m_phase <= P_FETCH; end
                P_HALT:  if (start) m_phase <= P_FETCH;
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    logic        e_req, e_br, e_inc;
    logic [15:0] e_bus;

    // Per-cycle comparison, sampled mid-low-phase once inputs have settled
    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            e_req = (m_phase == P_FETCH) || (m_phase == P_WAIT);
            e_br  = (m_phase == P_DECODE) &&
                    (m_ir[15:12] == 4'hE || (m_ir[15:12] == 4'hD && flag_z));
            e_inc = ((m_phase == P_DECODE) && m_ir[15:12] == 4'hD && !flag_z) ||
                    ((m_phase == P_ISSUE) && ir_ready);
            e_bus = e_br ? {10'd0, m_ir[5:0]} : 16'd0;
            chk("mem_req",  16'(mem_req),  16'(e_req));
            chk("branch",   16'(branch),   16'(e_br));
            chk("inc_pc",   16'(inc_pc),   16'(e_inc));
            chk("bus",      bus,           e_bus);
            chk("ir_valid", 16'(ir_valid), 16'(m_phase == P_ISSUE));
            chk("halted",   16'(halted),   16'(m_phase == P_HALT));
            chk("ir",       ir,            m_ir);
            chk("ir_addr",  16'(ir_addr),  16'(m_addr));
            chk("icount",   icount,        m_cnt);
            chk("err",      16'(err),      16'(m_err));
            chk("pulse_excl", 16'(inc_pc & branch), 16'd0);
        end
    end

    task automatic nx();
        @(negedge clk);
    endtask

    logic [3:0] r_op;
    bit         low_valid;

    initial begin
        // Reset and basic issue path
        nx(); rst = 1'b0;
        nx(); rst = 1'b1; cmp_en = 1'b1; start = 1'b1;
        #3 chk("rst_icount", icount, 16'd0); chk("rst_req", 16'(mem_req), 16'd0);
        chk("rst_ir", ir, 16'd0); chk("rst_err", 16'(err), 16'd0);
        nx(); start = 1'b0;
        #3 chk("d39_req_fetch", 16'(mem_req), 16'd1);
        nx(); mem_valid = 1'b1; mem_data = 16'h1234; pc_addr = 6'h10;
        #3 chk("d39_req_wait", 16'(mem_req), 16'd1);
        nx(); mem_valid = 1'b0;
        #3 chk("d39_ir", ir, 16'h1234); chk("d39_noval", 16'(ir_valid), 16'd0);
        nx(); ir_ready = 1'b1;
        #3 chk("d39_val", 16'(ir_valid), 16'd1); chk("d39_inc", 16'(inc_pc), 16'd1);
        chk("d39_addr", 16'(ir_addr), 16'h0010);
        nx(); ir_ready = 1'b0;
        #3 chk("d39_icount", icount, 16'd1); chk("d39_mdl_cnt", m_cnt, 16'd1);
        chk("d39_inc_off", 16'(inc_pc), 16'd0);
        // JMP
        nx(); mem_valid = 1'b1; mem_data = 16'hE02A;
        nx(); mem_valid = 1'b0;
        #3 chk("d40_br", 16'(branch), 16'd1); chk("d40_bus", bus, 16'h002A);
        chk("d40_noinc", 16'(inc_pc), 16'd0); chk("d40_noval", 16'(ir_valid), 16'd0);
        nx();
        #3 chk("d40_bus0", bus, 16'd0); chk("d40_fetch", 16'(mem_req), 16'd1);
        chk("d40_icount", icount, 16'd2);
        // JZ not taken, then taken
        nx(); mem_valid = 1'b1; mem_data = 16'hD005;
        nx(); mem_valid = 1'b0; flag_z = 1'b0;
        #3 chk("d41_inc", 16'(inc_pc), 16'd1); chk("d41_nobr", 16'(branch), 16'd0);
        nx();
        nx(); mem_valid = 1'b1; mem_data = 16'hD005;
        nx(); mem_valid = 1'b0; flag_z = 1'b1;
        #3 chk("d41_br", 16'(branch), 16'd1); chk("d41_bus", bus, 16'h0005);
        chk("d41_noinc", 16'(inc_pc), 16'd0);
        nx(); flag_z = 1'b0;
        #3 chk("d41_icount", icount, 16'd4);
        // Backpressure in ISSUE
        nx(); mem_valid = 1'b1; mem_data = 16'h3ABC; pc_addr = 6'h22;
        nx(); mem_valid = 1'b0; pc_addr = 6'h00;
        repeat (5) begin
            nx(); ir_ready = 1'b0;
            #3 chk("d42_val", 16'(ir_valid), 16'd1); chk("d42_ir", ir, 16'h3ABC);
            chk("d42_addr", 16'(ir_addr), 16'h0022); chk("d42_noinc", 16'(inc_pc), 16'd0);
        end
        nx(); ir_ready = 1'b1;
        #3 chk("d42_inc", 16'(inc_pc), 16'd1);
        nx(); ir_ready = 1'b0;
        #3 chk("d42_icount", icount, 16'd5);
        // Memory timeout
        repeat (15) begin
            nx();
            #3 chk("d43_wait_req", 16'(mem_req), 16'd1); chk("d43_not_halt", 16'(halted), 16'd0);
        end
        nx(); start = 1'b1;
        #3 chk("d43_halted", 16'(halted), 16'd1); chk("d43_err", 16'(err), 16'd1);
        chk("d43_noreq", 16'(mem_req), 16'd0);
        nx(); start = 1'b0;
        #3 chk("d43_resume", 16'(mem_req), 16'd1); chk("d43_err_kept", 16'(err), 16'd1);
        // Reset in WAIT
        nx(); rst = 1'b0;
        #3 chk("d44w_req", 16'(mem_req), 16'd1);
        nx(); rst = 1'b1; start = 1'b1;
        #3 chk("d44w_icount", icount, 16'd0); chk("d44w_err", 16'(err), 16'd0);
        chk("d44w_req0", 16'(mem_req), 16'd0); chk("d44w_val0", 16'(ir_valid), 16'd0);
        // Valid arriving in the 15th WAIT cycle beats the timeout
        nx(); start = 1'b0;
        repeat (14) nx();
        nx(); mem_valid = 1'b1; mem_data = 16'h1111;
        nx(); mem_valid = 1'b0;
        #3 chk("d25_nohalt", 16'(halted), 16'd0); chk("d25_noerr", 16'(err), 16'd0);
        chk("d25_ir", ir, 16'h1111);
        // Reset in ISSUE takes priority over the handshake
        nx(); rst = 1'b0; ir_ready = 1'b1;
        #3 chk("d44i_val", 16'(ir_valid), 16'd1);
        nx(); rst = 1'b1; ir_ready = 1'b0;
        #3 chk("d44i_icount", icount, 16'd0); chk("d44i_val0", 16'(ir_valid), 16'd0);
        chk("d44i_ir", ir, 16'd0);

        // Randomized traffic
        low_valid = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            nx();
            if (i % 250 == 0) low_valid = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 3) == 0);
            mem_valid = low_valid ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       r_op = 4'hF;
                1:       r_op = 4'hE;
                2:       r_op = 4'hD;
                default: r_op = 4'($urandom_range(0, 15));
            endcase
            mem_data = {r_op, 12'($urandom)};
            pc_addr  = 6'($urandom_range(0, 63));
            flag_z   = ($urandom_range(0, 1) == 1);
            ir_ready = ($urandom_range(0, 2) == 0);
        end
        nx();
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_fetch.md
IR_FETCH -- requirements
Module: ir_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 start  in  1  begin/resume fetching; level, sampled in IDLE and HALT only.
REQ-005 pc_addr  in  6  current program counter value (fetch address).
REQ-006 mem_req  out  1  program-memory read request for pc_addr.
REQ-007 mem_valid  in  1  memory read data valid; ignored outside WAIT.
REQ-008 mem_data  in  16  instruction word; sampled only with mem_valid in WAIT.
REQ-009 flag_z  in  1  zero flag from execute; sampled in DECODE only.
REQ-010 inc_pc  out  1  one-cycle pulse: PC += 1.
REQ-011 branch  out  1  one-cycle pulse: PC loads bus[5:0].
REQ-012 bus  out  16  branch target {10'b0, ir[5:0]}; 16'h0000 whenever branch=0.
REQ-013 ir  out  16  latched instruction.
REQ-014 ir_addr  out  6  pc_addr captured with ir.
REQ-015 ir_valid  out  1  ir offered to execute stage.
REQ-016 ir_ready  in  1  execute stage accepts ir.
REQ-017 icount  out  16  retired-instruction counter.
REQ-018 halted  out  1  high in HALT state.
REQ-019 err  out  1  sticky memory-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT, DECODE, ISSUE, HALT; every transition takes effect on a rising clk.
REQ-021 Opcode SHALL be ir[15:12]: 4'hF HALT, 4'hE JMP, 4'hD JZ; all others are passed to execute.
REQ-022 IDLE: all outputs low; start=1 -> FETCH; else stay.
REQ-023 FETCH: mem_req=1, wait counter cleared; unconditionally -> WAIT.
REQ-024 WAIT: mem_req=1; wait counter +1 per cycle; mem_valid=1 -> ir<=mem_data, ir_addr<=pc_addr, -> DECODE.
REQ-025 WAIT timeout: 15 consecutive WAIT cycles without mem_valid -> err<=1, -> HALT; mem_valid in the 15th cycle wins over timeout.
REQ-026 DECODE HALT: no pulse; icount +1; -> HALT.
REQ-027 DECODE JMP, or JZ with flag_z=1: branch=1 for this cycle only; bus driven as in REQ-012; icount +1; -> FETCH.
REQ-028 DECODE JZ with flag_z=0: inc_pc=1 this cycle; icount +1; -> FETCH.
REQ-029 DECODE other opcode: no pulse; -> ISSUE.
REQ-030 ISSUE: ir_valid=1, ir and ir_addr held stable until accepted; ir_valid=1 and ir_ready=1 -> inc_pc=1 that cycle, icount +1, -> FETCH.
REQ-031 ir_ready outside ISSUE SHALL be ignored; ir_valid SHALL never drop before acceptance.
REQ-032 inc_pc and branch SHALL never be high in the same cycle; neither SHALL be high outside DECODE/ISSUE.
REQ-033 HALT: halted=1; start=1 -> FETCH (PC untouched, err unchanged); else stay.
REQ-034 start outside IDLE/HALT SHALL be ignored.
REQ-035 icount SHALL wrap 16'hFFFF -> 16'h0000.
REQ-036 Latency: start in cycle 0 -> mem_req in cycle 1; mem_valid in cycle n -> DECODE in n+1 -> ir_valid (or pulse) in n+1/n+2.

Reset
REQ-037 rst=0 at a rising clk SHALL force IDLE and clear ir, ir_addr, icount, err, wait counter; all outputs low, bus=0, in the following cycle, from any state mid-operation.
REQ-038 rst has priority over every other input.

Verification
REQ-039 Reset, start=1, mem_valid one cycle after mem_req with 16'h1234, ir_ready=1 -> ir_valid next-but-one cycle, ir=16'h1234, inc_pc one pulse, icount=1.
REQ-040 mem_data=16'hE02A -> branch pulse, bus=16'h002A, no inc_pc, ir_valid never high, back to FETCH.
REQ-041 16'hD005 with flag_z=0 -> inc_pc pulse only; with flag_z=1 -> branch pulse, bus=16'h0005.
REQ-042 ir_ready held low 5 cycles in ISSUE -> ir_valid stays 1, ir stable, no inc_pc until ir_ready=1.
REQ-043 mem_valid never asserted -> after 15 WAIT cycles err=1, halted=1; start=1 -> mem_req again, err still 1.
REQ-044 rst=0 asserted in WAIT and in ISSUE -> next cycle IDLE, icount=0, err=0, mem_req=0, ir_valid=0.
